// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline slice.
// Holds the datapath widths, the MEM-stage state encoding and the MEM/WB bubble value.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0};

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: a flat capture stage with a bubble input.
// A bubble clears the control bits and leaves the data fields unchanged.
module mem_wb_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_W  = mips_pkg::REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bubble,
  input  logic              load_rdata,
  input  wb_ctrl_t          ctrl_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] rdata_in,
  output wb_ctrl_t          ctrl_out,
  output logic [REG_W-1:0]  rd_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] rdata_out
);

  wb_ctrl_t          ctrl_d, ctrl_q;
  logic [REG_W-1:0]  rd_d, rd_q;
  logic [DATA_W-1:0] alu_d, alu_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // Next-state selection: bubble or capture, read data only on a completed access
  always_comb begin
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    if (bubble) begin
      ctrl_d = WB_BUBBLE;
    end else begin
      ctrl_d = ctrl_in;
      rd_d   = rd_in;
      alu_d  = alu_in;
      if (load_rdata) begin
        rdata_d = rdata_in;
      end else begin
        rdata_d = rdata_q;
      end
    end
  end

  // Register update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= WB_BUBBLE;
      rd_q    <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
    end
  end

  assign ctrl_out  = ctrl_q;
  assign rd_out    = rd_q;
  assign alu_out   = alu_q;
  assign rdata_out = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS core: branch resolution, data-memory
// handshake with timeout and pipeline stall, and the MEM/WB register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int REG_W   = mips_pkg::REG_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] branch_address,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  input  logic [REG_W-1:0]  rd,
  input  logic              zeroflag,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              branch,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              flush,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              align_err,
  output logic              bus_err,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_read_data
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  mem_state_t        state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              mem_req_d, mem_req_q;
  logic              mem_we_d, mem_we_q;
  logic [DATA_W-1:0] mem_addr_d, mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
  logic              align_err_d, align_err_q;
  logic              bus_err_d, bus_err_q;

  logic     memop, misaligned, timeout_hit;
  logic     wb_bubble, wb_load_rdata;
  wb_ctrl_t wb_ctrl_in, wb_ctrl_out;

  assign memop       = mem_read | mem_write;
  assign misaligned  = memop & (alu_result[1:0] != 2'b00);
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST);

  // Branches never touch memory, so resolution ignores the stall
  assign pc_src        = branch & zeroflag;
  assign flush         = pc_src;
  assign branch_target = branch_address;

  // Handshake FSM next state, stall and MEM/WB bubble control
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    align_err_d   = align_err_q;
    bus_err_d     = bus_err_q;
    stall         = 1'b0;
    wb_bubble     = 1'b0;
    wb_load_rdata = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (memop && !misaligned) begin
          stall       = 1'b1;
          wb_bubble   = 1'b1;
          state_d     = REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = mem_write;
          mem_addr_d  = alu_result;
          mem_wdata_d = write_data;
        end else if (misaligned) begin
          wb_bubble   = 1'b1;
          align_err_d = 1'b1;
        end else begin
          wb_bubble = 1'b0;
        end
      end
      REQ: begin
        // Ack takes priority over a coincident timeout
        if (mem_ack) begin
          wb_load_rdata = 1'b1;
          state_d       = IDLE;
          cnt_d         = '0;
          mem_req_d     = 1'b0;
          mem_we_d      = 1'b0;
          mem_addr_d    = '0;
          mem_wdata_d   = '0;
        end else if (timeout_hit) begin
          wb_bubble   = 1'b1;
          bus_err_d   = 1'b1;
          state_d     = IDLE;
          cnt_d       = '0;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end else begin
          stall     = 1'b1;
          wb_bubble = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        mem_req_d = 1'b0;
        wb_bubble = 1'b1;
      end
    endcase
  end

  // FSM and memory-interface registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      align_err_q <= align_err_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign align_err = align_err_q;
  assign bus_err   = bus_err_q;

  assign wb_ctrl_in = '{reg_write: reg_write, mem_to_reg: mem_to_reg};

  mem_wb_reg #(
    .DATA_W(DATA_W),
    .REG_W (REG_W)
  ) u_mem_wb (
    .clk       (clk),
    .reset     (reset),
    .bubble    (wb_bubble),
    .load_rdata(wb_load_rdata),
    .ctrl_in   (wb_ctrl_in),
    .rd_in     (rd),
    .alu_in    (alu_result),
    .rdata_in  (mem_rdata),
    .ctrl_out  (wb_ctrl_out),
    .rd_out    (wb_rd),
    .alu_out   (wb_alu_result),
    .rdata_out (wb_read_data)
  );

  assign wb_reg_write  = wb_ctrl_out.reg_write;
  assign wb_mem_to_reg = wb_ctrl_out.mem_to_reg;

endmodule
